// File: rtl/tic_tac_toe_nxn.sv
// tic_tac_toe_nxn: N x N player (X) vs computer (O) controller with move validation and win/draw detection.
// Define MOVE_TIMEOUT_EN to give each move a TIMEOUT-cycle limit after which the idle side loses.
module tic_tac_toe_nxn #(
    parameter int N = 3,
    parameter int POS_W = $clog2(N*N+1),
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       play,
    input  logic [POS_W-1:0]           player_pos,
    input  logic                       player_vld,
    input  logic [POS_W-1:0]           comp_pos,
    input  logic                       comp_vld,
    output logic [2*N*N-1:0]           board,
    output logic                       turn,
    output logic                       game_over,
    output logic [1:0]                 winner,
    output logic                       illegal,
    output logic [$clog2(N*N+1)-1:0]   move_cnt
);
    localparam int CELLS = N*N;
    localparam int CW = $clog2(CELLS+1);
    typedef enum logic [2:0] {IDLE, P_MOVE, P_CHECK, C_MOVE, C_CHECK, DONE} state_t;
    state_t state, state_d;
    logic [2*CELLS-1:0] board_d;
    logic [1:0] winner_d;
    logic [CW-1:0] cnt_d;
    logic turn_d, over_d, illegal_d, p_ok, c_ok, win;
`ifdef MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0] tcnt, tcnt_d;
`endif
    // Out-of-range positions map to a non-empty code so the range check falls out of the empty check.
    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input logic [POS_W-1:0] pos);
        cell_at = 2'b11;
        for (int k = 0; k < CELLS; k++)
            if (int'(pos) == k + 1) cell_at = b[2*k +: 2];
    endfunction
    function automatic logic [2*CELLS-1:0] set_cell(input logic [2*CELLS-1:0] b, input logic [POS_W-1:0] pos, input logic [1:0] m);
        for (int k = 0; k < CELLS; k++)
            if (int'(pos) == k + 1) b[2*k +: 2] = m;
        return b;
    endfunction
    function automatic logic wins(input logic [2*CELLS-1:0] b, input logic [1:0] m);
        logic any, row, col, d0, d1;
        any = 1'b0;
        d0 = 1'b1;
        d1 = 1'b1;
        for (int i = 0; i < N; i++) begin
            row = 1'b1;
            col = 1'b1;
            for (int j = 0; j < N; j++) begin
                row &= b[2*(i*N+j) +: 2] == m;
                col &= b[2*(j*N+i) +: 2] == m;
            end
            any |= row | col;
            d0 &= b[2*(i*N+i) +: 2] == m;
            d1 &= b[2*(i*N+N-1-i) +: 2] == m;
        end
        return any | d0 | d1;
    endfunction
    always_comb begin
        state_d = state;
        board_d = board;
        turn_d = turn;
        winner_d = winner;
        over_d = game_over;
        cnt_d = move_cnt;
`ifdef MOVE_TIMEOUT_EN
        tcnt_d = '0;
`endif
        p_ok = player_vld && cell_at(board, player_pos) == 2'b00;
        c_ok = comp_vld && cell_at(board, comp_pos) == 2'b00;
        win = wins(board, state == P_CHECK ? 2'b01 : 2'b10);
        illegal_d = (player_vld && !(state == P_MOVE && p_ok)) || (comp_vld && !(state == C_MOVE && c_ok));
        case (state)
            IDLE, DONE:
                if (play) begin
                    state_d = P_MOVE;
                    board_d = '0;
                    cnt_d = '0;
                    winner_d = 2'b00;
                    over_d = 1'b0;
                    turn_d = 1'b0;
                end
            P_MOVE:
                if (p_ok) begin
                    board_d = set_cell(board, player_pos, 2'b01);
                    cnt_d = move_cnt + CW'(1);
                    state_d = P_CHECK;
                end
`ifdef MOVE_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT-1)) begin
                    state_d = DONE;
                    winner_d = 2'b10;
                    over_d = 1'b1;
                end else tcnt_d = tcnt + TW'(1);
`endif
            C_MOVE:
                if (c_ok) begin
                    board_d = set_cell(board, comp_pos, 2'b10);
                    cnt_d = move_cnt + CW'(1);
                    state_d = C_CHECK;
                end
`ifdef MOVE_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT-1)) begin
                    state_d = DONE;
                    winner_d = 2'b01;
                    over_d = 1'b1;
                end else tcnt_d = tcnt + TW'(1);
`endif
            P_CHECK, C_CHECK:
                if (win || move_cnt == CW'(CELLS)) begin
                    state_d = DONE;
                    over_d = 1'b1;
                    winner_d = !win ? 2'b11 : state == P_CHECK ? 2'b01 : 2'b10;
                end else begin
                    state_d = state == P_CHECK ? C_MOVE : P_MOVE;
                    turn_d = !turn;
                end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            board <= '0;
            turn <= 1'b0;
            game_over <= 1'b0;
            winner <= 2'b00;
            illegal <= 1'b0;
            move_cnt <= '0;
        end else begin
            state <= state_d;
            board <= board_d;
            turn <= turn_d;
            game_over <= over_d;
            winner <= winner_d;
            illegal <= illegal_d;
            move_cnt <= cnt_d;
        end
    end
`ifdef MOVE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) tcnt <= '0;
        else tcnt <= tcnt_d;
    end
`endif
endmodule
